// File: rtl/ifc_bundle.sv
// Shared signal bundle: derives value and a {val100,val200} struct from cyc, accepts
// consumer overrides, and flags any struct that disagrees with the bundle value.
module ifc_bundle #(
    parameter int W         = 32,
    parameter int VALUE_OFS = 1,
    parameter int OFS_A     = 100,
    parameter int OFS_B     = 200,
    parameter int DONE_CYC  = 20,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     cyc,
    input  logic             value_wr_en,
    input  logic [W-1:0]     value_wr_data,
    input  logic             struct_wr_en,
    input  logic [2*W-1:0]   struct_wr_data,
    output logic [W-1:0]     value,
    output logic [2*W-1:0]   the_struct,
    output logic             chk_err,
    output logic [CNT_W-1:0] err_count,
    output logic             done
);

    localparam logic [W-1:0] VALUE_OFS_W = W'(VALUE_OFS);
    localparam logic [W-1:0] DONE_CYC_W  = W'(DONE_CYC);
    localparam logic [W-1:0] DONE_VAL_W  = DONE_CYC_W + VALUE_OFS_W;
    // Element 1 is the upper field (val100), element 0 the lower field (val200).
    localparam logic [1:0][W-1:0] FIELD_OFS = {W'(OFS_A), W'(OFS_B)};

    logic [1:0][W-1:0] exp_field;
    logic [1:0]        field_bad;
    logic              mismatch;

    logic             chk_err_q, chk_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             done_q, done_d;

    assign value = value_wr_en ? value_wr_data : cyc + VALUE_OFS_W;

    // Each field is checked on its own against the (possibly overridden) value.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_field
            assign exp_field[gi] = value + FIELD_OFS[gi];
            assign field_bad[gi] = (the_struct[gi*W +: W] != exp_field[gi]);
        end
    endgenerate

    assign the_struct = struct_wr_en ? struct_wr_data : exp_field;
    assign mismatch   = |field_bad;

    always_comb begin
        chk_err_d   = mismatch;
        err_count_d = err_count_q;
        done_d      = done_q;
        if (mismatch && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
        if ((cyc == DONE_CYC_W) && (value == DONE_VAL_W)) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_q   <= 1'b0;
            err_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            chk_err_q   <= chk_err_d;
            err_count_q <= err_count_d;
            done_q      <= done_d;
        end
    end

    assign chk_err   = chk_err_q;
    assign err_count = err_count_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ifc_bundle.sv
// Self-checking bench for ifc_bundle: directed vector table, a small-counter instance for
// saturation and offset variants, and randomized traffic against a reference model.
module tb_ifc_bundle;

    logic        clk;
    logic        rst;
    logic [31:0] cyc;
    logic        value_wr_en;
    logic [31:0] value_wr_data;
    logic        struct_wr_en;
    logic [63:0] struct_wr_data;
    logic [31:0] value;
    logic [63:0] the_struct;
    logic        chk_err;
    logic [15:0] err_count;
    logic        done;

    logic        c2_rst;
    logic [31:0] c2_cyc;
    logic        c2_ven;
    logic [31:0] c2_vdata;
    logic        c2_sen;
    logic [63:0] c2_sdata;
    logic [31:0] c2_value;
    logic [63:0] c2_struct;
    logic        c2_chk;
    logic [3:0]  c2_cnt;
    logic        c2_done;

    int n_checks = 0;
    int n_errors = 0;

    ifc_bundle dut (
        .clk(clk), .rst(rst), .cyc(cyc),
        .value_wr_en(value_wr_en), .value_wr_data(value_wr_data),
        .struct_wr_en(struct_wr_en), .struct_wr_data(struct_wr_data),
        .value(value), .the_struct(the_struct), .chk_err(chk_err),
        .err_count(err_count), .done(done)
    );

    ifc_bundle #(.VALUE_OFS(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst(c2_rst), .cyc(c2_cyc),
        .value_wr_en(c2_ven), .value_wr_data(c2_vdata),
        .struct_wr_en(c2_sen), .struct_wr_data(c2_sdata),
        .value(c2_value), .the_struct(c2_struct), .chk_err(c2_chk),
        .err_count(c2_cnt), .done(c2_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [31:0] cyc;
        logic        ven;
        logic [31:0] vdata;
        logic        sen;
        logic [63:0] sdata;
        logic [31:0] e_value;
        logic [63:0] e_struct;
        logic        e_chk;
        logic [15:0] e_cnt;
        logic        e_done;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic r, input logic [31:0] c, input logic ve,
                                input logic [31:0] vd, input logic se, input logic [63:0] sd,
                                input logic [31:0] ev, input logic [63:0] es, input logic ec,
                                input logic [15:0] en, input logic ed);
        vec_t v;
        v.rst = r; v.cyc = c; v.ven = ve; v.vdata = vd; v.sen = se; v.sdata = sd;
        v.e_value = ev; v.e_struct = es; v.e_chk = ec; v.e_cnt = en; v.e_done = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] c, input logic ve,
                         input logic [31:0] vd, input logic se, input logic [63:0] sd);
        rst = r; cyc = c; value_wr_en = ve; value_wr_data = vd;
        struct_wr_en = se; struct_wr_data = sd;
    endtask

    task automatic drive2(input logic r, input logic [31:0] c, input logic se,
                          input logic [63:0] sd);
        c2_rst = r; c2_cyc = c; c2_ven = 1'b0; c2_vdata = 32'd0;
        c2_sen = se; c2_sdata = sd;
    endtask

    // Reference model state for the randomized phase
    logic        m_chk;
    int          m_cnt;
    logic        m_done;

    initial begin
        logic [31:0] ev;
        logic [63:0] es;
        logic        mis;
        logic        r;
        logic [31:0] c;
        logic        ve;
        logic [31:0] vd;
        logic        se;
        logic [63:0] sd;

        drive(1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 64'd0);
        drive2(1'b1, 32'd0, 1'b0, 64'd0);

        vecs[0]  = mk(0, 32'd0, 0, 0, 0, 0, 32'd1, {32'd101, 32'd201}, 0, 0, 0);
        vecs[1]  = mk(0, 32'd20, 0, 0, 0, 0, 32'd21, {32'd121, 32'd221}, 0, 0, 1);
        vecs[2]  = mk(0, 32'd5, 1, 32'd1021, 0, 0, 32'd1021, {32'd1121, 32'd1221}, 0, 0, 1);
        vecs[3]  = mk(0, 32'd4, 0, 0, 1, {32'd105, 32'd999}, 32'd5, {32'd105, 32'd999}, 1, 1, 1);
        vecs[4]  = mk(0, 32'd4, 0, 0, 1, {32'd105, 32'd999}, 32'd5, {32'd105, 32'd999}, 1, 2, 1);
        vecs[5]  = mk(0, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'd0, {32'd100, 32'd200}, 0, 2, 1);
        vecs[6]  = mk(0, 32'd7, 0, 0, 1, {32'd0, 32'd208}, 32'd8, {32'd0, 32'd208}, 1, 3, 1);
        vecs[7]  = mk(0, 32'd0, 1, 32'd50, 1, {32'd150, 32'd250}, 32'd50, {32'd150, 32'd250}, 0, 3, 1);
        vecs[8]  = mk(1, 32'd4, 0, 0, 1, {32'd105, 32'd999}, 32'd5, {32'd105, 32'd999}, 0, 0, 0);
        vecs[9]  = mk(0, 32'd20, 1, 32'd22, 0, 0, 32'd22, {32'd122, 32'd222}, 0, 0, 0);
        vecs[10] = mk(0, 32'd21, 0, 0, 0, 0, 32'd22, {32'd122, 32'd222}, 0, 0, 0);
        vecs[11] = mk(1, 32'd20, 0, 0, 0, 0, 32'd21, {32'd121, 32'd221}, 0, 0, 0);

        // Reset state
        @(posedge clk); #1;
        check("reset chk_err", 64'(chk_err), 64'd0);
        check("reset err_count", 64'(err_count), 64'd0);
        check("reset done", 64'(done), 64'd0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, vecs[i].cyc, vecs[i].ven, vecs[i].vdata, vecs[i].sen, vecs[i].sdata);
            #1;
            check($sformatf("vec%0d value", i), 64'(value), 64'(vecs[i].e_value));
            check($sformatf("vec%0d struct", i), the_struct, vecs[i].e_struct);
            @(posedge clk); #1;
            check($sformatf("vec%0d chk_err", i), 64'(chk_err), 64'(vecs[i].e_chk));
            check($sformatf("vec%0d err_count", i), 64'(err_count), 64'(vecs[i].e_cnt));
            check($sformatf("vec%0d done", i), 64'(done), 64'(vecs[i].e_done));
            $display("vec %0d: rst=%0d cyc=%0h value=%0h chk=%0d cnt=%0d done=%0d",
                     i, vecs[i].rst, vecs[i].cyc, value, chk_err, err_count, done);
        end

        // Offset-2 instance: done at cyc 20 with value 22, then counter saturation
        drive(1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 64'd0);
        drive2(1'b1, 32'd0, 1'b0, 64'd0);
        @(posedge clk); #1;
        drive2(1'b0, 32'd20, 1'b0, 64'd0);
        #1;
        check("ofs2 value", 64'(c2_value), 64'd22);
        check("ofs2 struct", c2_struct, {32'd122, 32'd222});
        @(posedge clk); #1;
        check("ofs2 done", 64'(c2_done), 64'd1);
        check("ofs2 chk_err", 64'(c2_chk), 64'd0);
        $display("ofs2: cyc=20 value=%0d done=%0d", c2_value, c2_done);
        for (int i = 0; i < 18; i++) begin
            drive2(1'b0, 32'd0, 1'b1, 64'd0);
            @(posedge clk); #1;
            check($sformatf("sat%0d chk_err", i), 64'(c2_chk), 64'd1);
            check($sformatf("sat%0d err_count", i), 64'(c2_cnt), 64'((i + 1 > 15) ? 15 : i + 1));
            $display("sat %0d: cnt=%0d", i, c2_cnt);
        end
        // Reset during an ongoing mismatch
        drive2(1'b1, 32'd20, 1'b1, 64'd0);
        @(posedge clk); #1;
        check("rstmis chk_err", 64'(c2_chk), 64'd0);
        check("rstmis err_count", 64'(c2_cnt), 64'd0);
        check("rstmis done", 64'(c2_done), 64'd0);
        $display("ofs2 reset: chk=%0d cnt=%0d done=%0d", c2_chk, c2_cnt, c2_done);
        drive2(1'b1, 32'd0, 1'b0, 64'd0);

        // Randomized traffic vs. reference model
        drive(1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 64'd0);
        @(posedge clk); #1;
        m_chk = 1'b0; m_cnt = 0; m_done = 1'b0;
        for (int t = 0; t < 400; t++) begin
            r = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 5))
                0, 1:    c = 32'd20;
                2:       c = 32'hFFFF_FFFF;
                3:       c = $urandom_range(0, 40);
                default: c = $urandom;
            endcase
            ve = ($urandom_range(0, 3) == 0);
            vd = ($urandom_range(0, 1) == 0) ? 32'd21 : $urandom;
            ev = ve ? vd : c + 32'd1;
            se = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       sd = {ev + 32'd100, ev + 32'd200};
                1:       sd = {ev + 32'd100, 32'(ev + 32'd200 + 32'($urandom_range(1, 9)))};
                2:       sd = {32'(ev + 32'd99), ev + 32'd200};
                default: sd = {$urandom, $urandom};
            endcase
            es  = se ? sd : {ev + 32'd100, ev + 32'd200};
            mis = (es[63:32] != ev + 32'd100) || (es[31:0] != ev + 32'd200);
            drive(r, c, ve, vd, se, sd);
            #1;
            check($sformatf("rnd%0d value", t), 64'(value), 64'(ev));
            check($sformatf("rnd%0d struct", t), the_struct, es);
            @(posedge clk); #1;
            if (r) begin
                m_chk = 1'b0; m_cnt = 0; m_done = 1'b0;
            end else begin
                m_chk = mis;
                if (mis && m_cnt < 65535) m_cnt++;
                if (c == 32'd20 && ev == 32'd21) m_done = 1'b1;
            end
            check($sformatf("rnd%0d chk_err", t), 64'(chk_err), 64'(m_chk));
            check($sformatf("rnd%0d err_count", t), 64'(err_count), 64'(m_cnt));
            check($sformatf("rnd%0d done", t), 64'(done), 64'(m_done));
            $display("rnd %0d: rst=%0d cyc=%0h ve=%0d se=%0d mis=%0d cnt=%0d done=%0d",
                     t, r, c, ve, se, mis, err_count, done);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
